// File: rtl/serial_add_sequencer.sv
// Bit-serial adder/subtractor: one full-adder cell walks the operands LSB first,
// with a valid/ready handshake on both the operand and the result side.
module serial_add_sequencer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carry_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry_out,
    output logic         busy
);

    // One extra bit so the counter can step past W-1 without wrapping.
    localparam int                CNT_W    = $clog2(W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [W-1:0]     a_sh_q,  a_sh_d;
    logic [W-1:0]     b_sh_q,  b_sh_d;
    logic [W-1:0]     res_q,   res_d;
    logic             carry_q, carry_d;

    logic fa_a;
    logic fa_b;
    logic fa_sum;
    logic fa_carry;

    // The single full-adder cell shared by every bit position.
    assign fa_a     = a_sh_q[0];
    assign fa_b     = b_sh_q[0];
    assign fa_sum   = fa_a ^ fa_b ^ carry_q;
    assign fa_carry = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));

    always_comb begin
        // NOTE: every variable gets a hold value before the case so no path
        // leaves one unassigned, which is what would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;
        carry_d   = carry_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ADD;
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : carry_in;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end

            ADD: begin
                busy          = 1'b1;
                res_d         = res_q >> 1;
                res_d[W-1]    = fa_sum;
                a_sh_d        = a_sh_q >> 1;
                b_sh_d        = b_sh_q >> 1;
                carry_d       = fa_carry;
                cnt_d         = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // Result registers are left alone so the output holds under back-pressure.
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the datapath registers are reset along with the state because sum
    // and carry_out are driven straight from them and must read zero in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
        end
    end

    assign sum       = res_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: directed cases on W=8, then
// randomized handshakes on W=8 and W=1 against an arithmetic reference.
module tb_serial_add_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       in_valid, in_ready, carry_in, sub, out_valid, out_ready, carry_out, busy;
    logic [7:0] a, b, sum;

    logic       in_valid1, in_ready1, carry_in1, sub1, out_valid1, out_ready1, carry_out1, busy1;
    logic [0:0] a1, b1, sum1;

    int total = 0;
    int bad   = 0;

    serial_add_sequencer #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .busy(busy)
    );

    serial_add_sequencer #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .carry_in(carry_in1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .carry_out(carry_out1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: A+B+cin, or A-B offset by 2^W so the top bit means "no borrow".
    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic cin, input logic s);
        int r;
        r = s ? (int'(x) - int'(y) + 256) : (int'(x) + int'(y) + int'(cin));
        return 9'(r);
    endfunction

    function automatic logic [1:0] model1(input logic x, input logic y,
                                          input logic cin, input logic s);
        int r;
        r = s ? (int'(x) - int'(y) + 2) : (int'(x) + int'(y) + int'(cin));
        return 2'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an operand set and returns just after the accepting edge.
    task automatic start8(input logic [7:0] ta, input logic [7:0] tb,
                          input logic tcin, input logic tsub);
        int k;
        a = ta; b = tb; carry_in = tcin; sub = tsub; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge until out_valid, plus busy samples.
    task automatic wait_done8(input bit noise, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (1) begin
            if (busy) bc++;
            if (out_valid || lat >= 100) break;
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                a = 8'($urandom);
                b = 8'($urandom);
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic handoff8(input int stall, input bit noise, output bit stable);
        logic [8:0] s0;
        s0 = {carry_out, sum};
        stable = 1'b1;
        repeat (stall) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                a = 8'($urandom);
            end
            tick();
            if (!out_valid || in_ready || ({carry_out, sum} !== s0)) stable = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("handoff_idle", {in_ready, out_valid, busy}, 3'b100);
    endtask

    task automatic rand8(input int n);
        logic [7:0] ta, tb;
        logic       tc, ts;
        int         lat, bc;
        bit         st;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            ta = 8'($urandom); tb = 8'($urandom);
            tc = 1'($urandom); ts = 1'($urandom);
            start8(ta, tb, tc, ts);
            wait_done8(1'b1, lat, bc);
            check("rnd8_lat", lat, 8);
            check("rnd8_res", {carry_out, sum}, model8(ta, tb, tc, ts));
            handoff8($urandom_range(0, 3), 1'b1, st);
            check("rnd8_stall", st, 1'b1);
            if (bad != 0) break;
        end
    endtask

    task automatic rand1(input int n);
        logic       ta, tb, tc, ts;
        logic [1:0] s0;
        int         lat;
        bit         st;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            ta = 1'($urandom); tb = 1'($urandom);
            tc = 1'($urandom); ts = 1'($urandom);
            a1 = ta; b1 = tb; carry_in1 = tc; sub1 = ts; in_valid1 = 1'b1;
            check("rnd1_ready", in_ready1, 1'b1);
            tick();
            in_valid1 = 1'($urandom_range(0, 1));
            a1 = 1'($urandom);
            lat = 1;
            tick();
            while (!out_valid1 && lat < 20) begin
                tick();
                lat++;
            end
            check("rnd1_lat", lat, 1);
            check("rnd1_res", {carry_out1, sum1}, model1(ta, tb, tc, ts));
            s0 = {carry_out1, sum1};
            st = 1'b1;
            repeat ($urandom_range(0, 3)) begin
                tick();
                if (!out_valid1 || ({carry_out1, sum1} !== s0)) st = 1'b0;
            end
            check("rnd1_stall", st, 1'b1);
            in_valid1  = 1'b0;
            out_ready1 = 1'b1;
            tick();
            out_ready1 = 1'b0;
            if (bad != 0) break;
        end
    endtask

    initial begin
        int  lat, bc;
        bit  st, seen;
        logic [8:0] s0;

        rst_n = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; carry_in1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_ctrl", {in_ready, out_valid, busy}, 3'b100);
        check("rst_sum", {carry_out, sum}, 9'h000);
        check("rst_w1", {in_ready1, out_valid1, busy1, carry_out1, sum1}, 5'b10000);
        repeat (2) tick();
        rst_n = 1'b1;

        // First edge after reset release accepts; 0F + 01.
        out_ready = 1'b1;
        start8(8'h0F, 8'h01, 1'b0, 1'b0);
        wait_done8(1'b0, lat, bc);
        check("d1_lat", lat, 8);
        check("d1_busy_cycles", bc, 8);
        check("d1_res", {carry_out, sum}, 9'h010);
        handoff8(0, 1'b0, st);

        start8(8'hFF, 8'h01, 1'b1, 1'b0);
        wait_done8(1'b0, lat, bc);
        check("d2_res", {carry_out, sum}, 9'h101);
        handoff8(0, 1'b0, st);

        start8(8'h05, 8'h07, 1'b1, 1'b1);
        wait_done8(1'b0, lat, bc);
        check("d3_borrow", {carry_out, sum}, 9'h0FE);
        handoff8(0, 1'b0, st);

        // Back-pressure with the next operand set already waiting.
        start8(8'h3C, 8'h5A, 1'b0, 1'b0);
        wait_done8(1'b0, lat, bc);
        check("bp_res", {carry_out, sum}, 9'h096);
        a = 8'h11; b = 8'h22; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        s0 = {carry_out, sum};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {out_valid, carry_out, sum}, {1'b1, s0});
            check("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_bubble", {in_ready, busy, out_valid}, 3'b100);
        tick();
        check("bp_accept", busy, 1'b1);
        in_valid = 1'b0;
        wait_done8(1'b0, lat, bc);
        check("bp2_lat", lat, 8);
        check("bp2_res", {carry_out, sum}, 9'h033);
        handoff8(0, 1'b0, st);

        // Reset three cycles into an operation.
        start8(8'hFF, 8'hFF, 1'b1, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", {in_ready, out_valid, busy}, 3'b100);
        check("mid_rst_sum", {carry_out, sum}, 9'h000);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_valid", seen, 1'b0);
        start8(8'h02, 8'h03, 1'b0, 1'b0);
        wait_done8(1'b0, lat, bc);
        check("post_rst_lat", lat, 8);
        check("post_rst_res", {carry_out, sum}, 9'h005);
        handoff8(0, 1'b0, st);

        rand8(1000);
        rand1(1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 Parameter: W, default 8, operand width in bits; legal range W >= 1.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand set on a, b, carry_in and sub is valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 carry_in  input  1  initial carry; used only when sub=0.
REQ-009 sub  input  1  1 selects A - B, 0 selects A + B + carry_in.
REQ-010 out_valid  output  1  sum and carry_out hold a completed result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  W  result bits.
REQ-013 carry_out  output  1  final carry; for sub=1, 1 means no borrow (A >= B).
REQ-014 busy  output  1  high in ADD state.

Function
REQ-015 The datapath SHALL contain exactly one 1-bit full-adder stage, reused once per bit, LSB first; no W-bit adder shall be inferred.
REQ-016 FSM states SHALL be IDLE, ADD and DONE; in_ready=1 only in IDLE, busy=1 only in ADD, out_valid=1 only in DONE.
REQ-017 IDLE -> ADD on in_valid & in_ready; at that edge the block loads A_sh<=a, B_sh<=(sub ? ~b : b), carry register <= (sub ? 1 : carry_in), bit counter <= 0, result register <= 0.
REQ-018 In each ADD cycle the full-adder inputs SHALL be A_sh[0], B_sh[0] and the carry register; at the edge the sum bit is shifted into result[W-1] (result shifts right), A_sh and B_sh shift right, carry register <= adder carry, counter increments.
REQ-019 ADD -> DONE at the edge where counter == W-1; the counter SHALL be $clog2(W)+1 bits wide and never wrap within one operation.
REQ-020 Latency: out_valid SHALL rise exactly W clock edges after the accepting edge (W=1: one edge).
REQ-021 In DONE, sum SHALL equal the result register and carry_out the carry register, i.e. {carry_out, sum} == a + b + carry_in modulo 2^(W+1) for sub=0, and a + ~b + 1 for sub=1.
REQ-022 While out_valid & ~out_ready, sum, carry_out and out_valid SHALL remain stable for any number of cycles.
REQ-023 DONE -> IDLE on out_valid & out_ready; in_ready rises the cycle after; no operand is accepted in the same cycle as result hand-off (one bubble cycle per operation).
REQ-024 in_valid asserted in ADD or DONE SHALL be ignored and SHALL NOT disturb internal state; the operand set is accepted only once IDLE is reached and in_valid is still high.
REQ-025 Outside DONE, sum and carry_out SHALL be driven with the result and carry registers but carry no meaning; consumers use out_valid only.

Reset
REQ-026 rst_n low SHALL immediately, without a clock edge, force state=IDLE, counter, shift registers, result and carry registers to 0; thus in_ready=1, out_valid=0, busy=0, sum=0, carry_out=0.
REQ-027 Reset asserted during ADD or DONE SHALL discard the operation; no out_valid pulse shall follow it.
REQ-028 After rst_n rises, the first operand set SHALL be accepted on the first rising edge with in_valid=1.

Verification
REQ-029 W=8, a=8'h0F, b=8'h01, carry_in=0, sub=0, out_ready=1 -> out_valid rises 8 edges after accept, sum=8'h10, carry_out=0, busy high for 8 cycles.
REQ-030 W=8, a=8'hFF, b=8'h01, carry_in=1, sub=0 -> sum=8'h01, carry_out=1; then a=8'h05, b=8'h07, sub=1, carry_in=1 -> sum=8'hFE, carry_out=0 (borrow).
REQ-031 Back-pressure: out_ready held 0 for 5 cycles after out_valid, in_valid held 1 with new operands -> sum/carry_out stable, in_ready stays 0, new operands accepted only one edge after out_ready=1 hand-off.
REQ-032 Reset mid-operation: rst_n pulsed low 3 cycles after accept -> outputs zero asynchronously, no out_valid, next operand a=8'h02, b=8'h03 yields sum=8'h05 after 8 edges.
REQ-033 W=1 and W=8 random: 1000 operand sets with random sub, carry_in, in_valid and out_ready gaps -> every {carry_out, sum} matches the REQ-021 model, first mismatch ends the run with an error.
